// File: rtl/swervolf_irq_pkg.sv
// Shared constants for the SweRVolf interrupt arbiter:
// register map, claim word layout and a byte-lane helper.
package swervolf_irq_pkg;

  localparam int ID_W            = 5;
  localparam int CLAIM_VALID_BIT = 31;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_EDGE    = 3'd2;
  localparam logic [2:0] REG_ROUTE   = 3'd3;
  localparam logic [2:0] REG_CLAIM3  = 3'd4;
  localparam logic [2:0] REG_CLAIM4  = 3'd5;
  localparam logic [2:0] REG_INSERV  = 3'd6;
  localparam logic [2:0] REG_INFO    = 3'd7;

  function automatic logic [31:0] byte_mask(
    input logic [3:0] sel
  );
    return {{8{sel[3]}}, {8{sel[2]}},
            {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/swervolf_irq_arbiter_if.sv
// Wishbone slave bundle of the interrupt arbiter, same shape
// as the system controller port.
interface swervolf_irq_arbiter_if;

  logic [5:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel,
    output i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel,
    input  i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );

endinterface

// File: rtl/swervolf_irq_prio_enc.sv
// Lowest-index find-first-set; id is bit index + 1,
// id 0 when nothing is requested.
module swervolf_irq_prio_enc
  import swervolf_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/swervolf_irq_arbiter.sv
// SweRVolf interrupt arbiter: shares irq3/irq4 among N_SRC
// peripheral sources with a Wishbone claim/complete interface.
module swervolf_irq_arbiter
  import swervolf_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_SRC-1:0]      i_src,
  swervolf_irq_arbiter_if.slave wb,
  output logic                  o_irq3,
  output logic                  o_irq4
);

  typedef logic [N_SRC-1:0] vec_t;

  vec_t sync1, sync2, prev;
  vec_t lat_q, en_q, edge_q, route_q, is_q;
  vec_t pend, elig, rise;
  vec_t claim_set, cmp_clr, wm, wd;

  logic [31:0]     wmask;
  logic [31:0]     rd_mux;
  logic [2:0]      reg_sel;
  logic            bus, rd_fire, wr_fire;
  logic            v3, v4;
  logic [ID_W-1:0] id3, id4, cmp_id;
  logic            unused_ok;

  assign reg_sel = wb.i_wb_adr[4:2];
  assign bus     = wb.i_wb_cyc & wb.i_wb_stb
                 & ~wb.o_wb_ack;
  assign rd_fire = bus & ~wb.i_wb_we;
  assign wr_fire = bus & wb.i_wb_we;
  assign wmask   = byte_mask(wb.i_wb_sel);
  assign wm      = wmask[N_SRC-1:0];
  assign wd      = wb.i_wb_dat[N_SRC-1:0];
  assign cmp_id  = wb.i_wb_dat[ID_W-1:0];

  // edge sources use the sticky latch, level ones the synced level
  assign pend = (edge_q & lat_q) | (~edge_q & prev);
  assign elig = pend & en_q & ~is_q;
  assign rise = sync2 & ~prev & edge_q;

  swervolf_irq_prio_enc #(.N(N_SRC)) u_enc3 (
    .i_req   (elig & ~route_q),
    .o_valid (v3),
    .o_id    (id3)
  );

  swervolf_irq_prio_enc #(.N(N_SRC)) u_enc4 (
    .i_req   (elig & route_q),
    .o_valid (v4),
    .o_id    (id4)
  );

  always_comb begin
    claim_set = '0;
    cmp_clr   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rd_fire) begin
        if (reg_sel == REG_CLAIM3 && v3
            && id3 == ID_W'(i + 1))
          claim_set[i] = 1'b1;
        if (reg_sel == REG_CLAIM4 && v4
            && id4 == ID_W'(i + 1))
          claim_set[i] = 1'b1;
      end
      if (wr_fire && wb.i_wb_sel[0]
          && cmp_id == ID_W'(i + 1) && is_q[i]) begin
        if (reg_sel == REG_CLAIM3 && !route_q[i])
          cmp_clr[i] = 1'b1;
        if (reg_sel == REG_CLAIM4 && route_q[i])
          cmp_clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (reg_sel == REG_PENDING):
        rd_mux[N_SRC-1:0] = pend;
      (reg_sel == REG_ENABLE):
        rd_mux[N_SRC-1:0] = en_q;
      (reg_sel == REG_EDGE):
        rd_mux[N_SRC-1:0] = edge_q;
      (reg_sel == REG_ROUTE):
        rd_mux[N_SRC-1:0] = route_q;
      (reg_sel == REG_CLAIM3): begin
        rd_mux[CLAIM_VALID_BIT] = v3;
        rd_mux[ID_W-1:0]        = id3;
      end
      (reg_sel == REG_CLAIM4): begin
        rd_mux[CLAIM_VALID_BIT] = v4;
        rd_mux[ID_W-1:0]        = id4;
      end
      (reg_sel == REG_INSERV):
        rd_mux[N_SRC-1:0] = is_q;
      (reg_sel == REG_INFO):
        rd_mux = 32'(N_SRC);
      default:
        rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_src;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // a new edge in the claim cycle wins over the claim clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_q   <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      route_q <= '0;
      is_q    <= '0;
    end else begin
      lat_q <= (lat_q & ~(claim_set & edge_q)) | rise;
      is_q  <= (is_q & ~cmp_clr) | claim_set;
      if (wr_fire && reg_sel == REG_ENABLE)
        en_q <= (en_q & ~wm) | (wd & wm);
      if (wr_fire && reg_sel == REG_EDGE)
        edge_q <= (edge_q & ~wm) | (wd & wm);
      if (wr_fire && reg_sel == REG_ROUTE)
        route_q <= (route_q & ~wm) | (wd & wm);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
      o_irq3      <= 1'b0;
      o_irq4      <= 1'b0;
    end else begin
      wb.o_wb_ack <= bus;
      if (rd_fire) wb.o_wb_rdt <= rd_mux;
      o_irq3 <= |(elig & ~route_q);
      o_irq4 <= |(elig & route_q);
    end
  end

  assign unused_ok = ^{wb.i_wb_adr[5],
                       wb.i_wb_adr[1:0],
                       wb.i_wb_dat[31:N_SRC],
                       wmask[31:N_SRC]};

endmodule

// File: tb/tb_swervolf_irq_arbiter.sv
// Directed bench for swervolf_irq_arbiter with a cycle-level
// reference model and hand-computed register expectations.
module tb_swervolf_irq_arbiter;
  import swervolf_irq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic         irq3, irq4;

  swervolf_irq_arbiter_if wb ();

  swervolf_irq_arbiter #(.N_SRC(N)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_src  (src),
    .wb     (wb),
    .o_irq3 (irq3),
    .o_irq4 (irq4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: samples of i_src, per-source flags
  logic [N-1:0] smp [3];
  bit m_lat [N];
  bit m_en [N];
  bit m_edge [N];
  bit m_route [N];
  bit m_is [N];
  bit m_irq3, m_irq4, m_ack;
  bit [31:0] m_rdt;

  function automatic bit m_pend(input int i);
    return m_edge[i] ? m_lat[i] : smp[2][i];
  endfunction

  function automatic bit m_elig(input int i);
    return m_pend(i) && m_en[i] && !m_is[i];
  endfunction

  function automatic int m_first(input bit r);
    for (int i = 0; i < N; i++)
      if (m_elig(i) && m_route[i] == r) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) smp[k] = '0;
    for (int i = 0; i < N; i++) begin
      m_lat[i] = 0; m_en[i] = 0; m_edge[i] = 0;
      m_route[i] = 0; m_is[i] = 0;
    end
    m_irq3 = 0; m_irq4 = 0; m_ack = 0; m_rdt = '0;
  endtask

  task automatic model_step();
    bit n3, n4, fire;
    bit rise [N];
    int c, id;
    logic [2:0] idx;
    bit [31:0] rdv;
    n3 = 0;
    n4 = 0;
    for (int i = 0; i < N; i++) begin
      if (m_elig(i)) begin
        if (m_route[i]) n4 = 1; else n3 = 1;
      end
      rise[i] = smp[1][i] && !smp[2][i] && m_edge[i];
    end
    fire = wb.i_wb_cyc && wb.i_wb_stb && !m_ack;
    idx = wb.i_wb_adr[4:2];
    if (fire && !wb.i_wb_we) begin
      rdv = '0;
      case (idx)
        3'd0: for (int i = 0; i < N; i++) rdv[i] = m_pend(i);
        3'd1: for (int i = 0; i < N; i++) rdv[i] = m_en[i];
        3'd2: for (int i = 0; i < N; i++) rdv[i] = m_edge[i];
        3'd3: for (int i = 0; i < N; i++) rdv[i] = m_route[i];
        3'd4, 3'd5: begin
          c = m_first(idx == 3'd5);
          if (c >= 0) begin
            rdv = 32'h8000_0000 | 32'(c + 1);
            m_is[c] = 1;
            if (m_edge[c]) m_lat[c] = 0;
          end
        end
        3'd6: for (int i = 0; i < N; i++) rdv[i] = m_is[i];
        default: rdv = N;
      endcase
      m_rdt = rdv;
    end
    if (fire && wb.i_wb_we) begin
      for (int i = 0; i < N; i++) begin
        if (wb.i_wb_sel[i/8]) begin
          if (idx == 3'd1) m_en[i] = wb.i_wb_dat[i];
          if (idx == 3'd2) m_edge[i] = wb.i_wb_dat[i];
          if (idx == 3'd3) m_route[i] = wb.i_wb_dat[i];
        end
      end
      if ((idx == 3'd4 || idx == 3'd5) && wb.i_wb_sel[0]) begin
        id = int'(wb.i_wb_dat[4:0]);
        if (id >= 1 && id <= N)
          if (m_is[id-1] && m_route[id-1] == (idx == 3'd5))
            m_is[id-1] = 0;
      end
    end
    for (int i = 0; i < N; i++) if (rise[i]) m_lat[i] = 1;
    m_ack = fire;
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = src;
    m_irq3 = n3;
    m_irq4 = n4;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cyc_irq3", irq3, m_irq3);
        chk("cyc_irq4", irq4, m_irq4);
        chk("cyc_ack", wb.o_wb_ack, m_ack);
        if (m_ack) chk("cyc_rdt", wb.o_wb_rdt, m_rdt);
      end
    end
  end

  task automatic xfer(input bit we, input logic [5:0] adr,
                      input logic [31:0] dat,
                      input logic [3:0] sel,
                      output logic [31:0] rdt);
    bit got;
    got = 0;
    rdt = '0;
    wb.i_wb_cyc = 1; wb.i_wb_stb = 1; wb.i_wb_we = we;
    wb.i_wb_adr = adr; wb.i_wb_dat = dat; wb.i_wb_sel = sel;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (wb.o_wb_ack) begin
        got = 1;
        rdt = wb.o_wb_rdt;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack want ack at %h", adr);
    end
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0;
  endtask

  task automatic rd(input logic [5:0] adr,
                    input logic [31:0] exp, input string nm);
    logic [31:0] v;
    xfer(1'b0, adr, 32'h0, 4'hF, v);
    chk(nm, v, exp);
  endtask

  task automatic wr(input logic [5:0] adr,
                    input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] v;
    xfer(1'b1, adr, dat, sel, v);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0;
    wb.i_wb_adr = '0; wb.i_wb_dat = '0; wb.i_wb_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", wb.o_wb_ack, 0);
    chk("rst_rdt", wb.o_wb_rdt, 0);
    rst = 0;

    // 1: reset values of every register
    for (int a = 0; a < 8; a++)
      rd(6'(a * 4), (a == 7) ? 32'd8 : 32'd0, "t1_reg");
    chk("t1_irq3", irq3, 0);
    chk("t1_irq4", irq4, 0);

    // 2: edge source 0 on irq3, claim and complete
    wr(6'h04, 32'h05, 4'hF);
    wr(6'h08, 32'h01, 4'hF);
    wr(6'h0C, 32'h00, 4'hF);
    src[0] = 1;
    @(negedge clk); chk("t2_lat1", irq3, 0);
    src[0] = 0;
    @(negedge clk); chk("t2_lat2", irq3, 0);
    @(negedge clk); chk("t2_lat3", irq3, 0);
    @(negedge clk); chk("t2_rise", irq3, 1);
    rd(6'h10, 32'h8000_0001, "t2_claim3");
    @(negedge clk); chk("t2_fall", irq3, 0);
    rd(6'h18, 32'h01, "t2_inservice");
    wr(6'h10, 32'd1, 4'hF);
    rd(6'h18, 32'h00, "t2_complete");

    // 3: level source 2
    src[2] = 1;
    repeat (5) @(negedge clk);
    chk("t3_high", irq3, 1);
    rd(6'h10, 32'h8000_0003, "t3_claim3");
    @(negedge clk); chk("t3_fall", irq3, 0);
    wr(6'h10, 32'd3, 4'hF);
    @(negedge clk); chk("t3_reassert", irq3, 1);
    src[2] = 0;
    repeat (5) @(negedge clk);
    chk("t3_drop", irq3, 0);

    // 4: two edge sources split across irq3/irq4
    wr(6'h0C, 32'h02, 4'hF);
    wr(6'h04, 32'h03, 4'hF);
    wr(6'h08, 32'h03, 4'hF);
    src[1:0] = 2'b11;
    @(negedge clk);
    src[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    chk("t4_irq3", irq3, 1);
    chk("t4_irq4", irq4, 1);
    rd(6'h14, 32'h8000_0002, "t4_claim4");
    rd(6'h10, 32'h8000_0001, "t4_claim3");
    wr(6'h10, 32'd1, 4'hF);

    // 5: empty claim, ignored completes, byte lanes
    rd(6'h10, 32'h0, "t5_empty");
    rd(6'h18, 32'h02, "t5_is_kept");
    wr(6'h10, 32'd7, 4'hF);
    wr(6'h10, 32'd2, 4'hF);
    wr(6'h10, 32'd0, 4'hF);
    wr(6'h14, 32'd9, 4'hF);
    rd(6'h18, 32'h02, "t5_ignored");
    wr(6'h04, 32'hFF, 4'hE);
    rd(6'h04, 32'h03, "t5_lane");
    wr(6'h14, 32'd2, 4'hF);
    rd(6'h18, 32'h00, "t5_done");

    // 6: new edge in the claim cycle, then reset mid-read
    wr(6'h0C, 32'h00, 4'hF);
    wr(6'h04, 32'h01, 4'hF);
    wr(6'h08, 32'h01, 4'hF);
    src[0] = 1;
    @(negedge clk);
    src[0] = 0;
    repeat (4) @(negedge clk);
    chk("t6_irq3", irq3, 1);
    @(negedge clk); src[0] = 1;
    @(negedge clk); src[0] = 0;
    @(negedge clk);
    rd(6'h10, 32'h8000_0001, "t6_claim");
    rd(6'h00, 32'h01, "t6_set_wins");
    rd(6'h18, 32'h01, "t6_is");
    wr(6'h10, 32'd1, 4'hF);
    @(negedge clk); chk("t6_after_cmp", irq3, 1);
    rd(6'h10, 32'h8000_0001, "t6_reclaim");
    wb.i_wb_cyc = 1; wb.i_wb_stb = 1; wb.i_wb_we = 0;
    wb.i_wb_adr = 6'h18;
    #1 rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_ack", wb.o_wb_ack, 0);
      chk("t6_rst_irq3", irq3, 0);
    end
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0;
    rst = 0;
    rd(6'h18, 32'h0, "t6_rst_is");
    rd(6'h04, 32'h0, "t6_rst_en");
    rd(6'h00, 32'h0, "t6_rst_pend");
    chk("t6_end_irq3", irq3, 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/swervolf_irq_arbiter.md
Name: swervolf_irq_arbiter

Overview:
Shares the two SweRV external interrupt lines (irq3, irq4) among N_SRC peripheral interrupt sources such as GPIO, GPIO2, PTC and SPI. Each source can be enabled, set to edge or level mode, and routed to irq3 or irq4. Software acknowledges an interrupt with a claim/complete handshake over a Wishbone slave, using the same bus shape as the system controller. The block sits beside the system controller on the Wishbone interconnect and drives the core's irq3/irq4 inputs.

Parameters:
N_SRC, 8, number of interrupt sources (1..31); source id = bit index + 1, id 0 = none

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_src  in  N_SRC  raw interrupt requests, asynchronous to i_clk, active-high
i_wb_adr  in  6  byte address; bits [4:2] select the register
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte enables
i_wb_we  in  1  write strobe
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_rdt  out  32  registered read data
o_wb_ack  out  1  single-cycle acknowledge
o_irq3  out  1  aggregated interrupt to core irq3
o_irq4  out  1  aggregated interrupt to core irq4

Behaviour:
- Reset: asynchronous, active-high. Clears every register, synchroniser and output to 0 (o_wb_ack, o_wb_rdt, o_irq3, o_irq4 = 0).
- Bus handshake:
  - o_wb_ack <= cyc & stb & !o_wb_ack, giving 1 wait state.
  - A write takes effect on the cycle that ack rises. Byte lane 0 gates bits [7:0], lane 1 gates [15:8], and so on.
  - Read data is registered alongside ack.
  - Read side effects fire once per access, gated by cyc & stb & !we & !o_wb_ack.
- Registers (offsets):
  - 0x00 PENDING (RO)
  - 0x04 ENABLE (RW)
  - 0x08 EDGE (RW; 1 = rising-edge, 0 = level)
  - 0x0C ROUTE (RW; 1 = irq4, 0 = irq3)
  - 0x10 CLAIM3 (R = claim, W = complete)
  - 0x14 CLAIM4 (R = claim, W = complete)
  - 0x18 INSERVICE (RO)
  - 0x1C reads N_SRC
  - Unused bits read 0.
- Input path:
  - 2-flop synchroniser per source, followed by a previous-value register for edge detection.
  - Edge mode: pending bit latches on a 0->1 transition of the synchronised signal and is cleared by a claim.
  - Level mode: pending equals the synchronised level and is not latched.
- Eligible[i] = pending & enable & ~inservice.
  - o_irq3 is registered as OR of eligible bits with route = 0.
  - o_irq4 is registered as OR of eligible bits with route = 1.
- Latency: a rising i_src edge in cycle k sets pending at k+3 and asserts o_irq at k+4.
- Claim (read CLAIMx):
  - Selects the lowest-index eligible source routed to x.
  - Returns {1'b1 at bit31, id at [4:0]}, sets inservice[i], and clears pending[i] if the source is in edge mode.
  - With no eligible source, returns 0 and has no side effect.
- Complete (write CLAIMx with id in [4:0]):
  - Clears inservice[id-1] only if that source is in service and routed to x.
  - Otherwise the write is ignored, including id 0 and id > N_SRC.
- Simultaneous events:
  - A new edge in the same cycle as a claim clearing pending: set wins, so the new edge stays pending.
  - Changing ROUTE or ENABLE while a source is in service does not clear inservice.
  - A level source still high after complete re-asserts o_irq on the next cycle.
- Mid-operation reset: aborts any bus cycle (no ack) and drops all inservice state.

Decomposition:
- Package swervolf_irq_pkg holds:
  - register offset localparams (REG_PENDING .. REG_INFO);
  - CLAIM_VALID_BIT = 31;
  - ID_W = 5.
- Sub-module swervolf_irq_prio_enc is a parameterised lowest-index find-first-set returning {valid, id}. It is instantiated twice, once for the irq3 set and once for the irq4 set.

Test Plan:
1. Reset, then read 0x00–0x1C -> all read 0 except 0x1C = 8; o_irq3 = o_irq4 = 0.
2. ENABLE = 0x05, EDGE = 0x01, ROUTE = 0; pulse i_src[0] for 1 cycle -> o_irq3 rises 4 cycles later. Read 0x10 -> 0x8000_0001; o_irq3 falls; INSERVICE = 0x01. Write 0x10 = 1 -> INSERVICE = 0.
3. Hold level source i_src[2] high (ENABLE bit 2, level mode), claim -> 0x8000_0003. Complete while still high -> o_irq3 re-asserts the next cycle. Drop i_src[2] -> o_irq3 = 0.
4. ROUTE = 0x02, ENABLE = 0x03, both sources edge-mode and pulsed together -> o_irq3 and o_irq4 both high. CLAIM4 read -> 0x8000_0002; CLAIM3 read -> 0x8000_0001.
5. Claim with nothing pending -> read returns 0 and INSERVICE is unchanged. Complete id 7 when not in service -> no change.
6. Pulse i_src[0] again in the exact cycle a claim clears its pending -> pending stays 1 and o_irq3 stays high once complete is written. Assert i_rst mid-bus-read -> no ack, all state returns to 0.
